// File: rtl/warp_dispatch_scheduler_pkg.sv
// Shared types and constants for the warp dispatch scheduler.
package noc_sched_pkg;
  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } sched_state_t;
endpackage

// File: rtl/warp_dispatch_scheduler_if.sv
// Bundle of warp-issue requests and per-core dispatch signals around the scheduler.
interface warp_dispatch_scheduler_if #(
  parameter int unsigned W           = 32,
  parameter int unsigned NUM_THREADS = 32,
  parameter int unsigned NUM_WARPS   = 4
);
  import noc_sched_pkg::*;
  localparam int unsigned WID = $clog2(NUM_WARPS);

  logic [NUM_WARPS-1:0]                            warp_req_valid;
  logic [NUM_WARPS-1:0]                            warp_req_ready;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0]           warp_active_mask;
  logic [NUM_WARPS-1:0][OPCODE_W-1:0]              warp_opcode;
  logic [NUM_WARPS-1:0]                            warp_is_fp;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0][W-1:0]    warp_op1;
  logic [NUM_WARPS-1:0][NUM_THREADS-1:0][W-1:0]    warp_op2;
  logic [NUM_THREADS-1:0]                          core_ready;
  logic [NUM_THREADS-1:0]                          thread_valid;
  logic [NUM_THREADS-1:0][OPCODE_W-1:0]            thread_opcode;
  logic [NUM_THREADS-1:0]                          thread_is_fp;
  logic [NUM_THREADS-1:0][W-1:0]                   thread_op1;
  logic [NUM_THREADS-1:0][W-1:0]                   thread_op2;
  logic                                            busy;
  logic [WID-1:0]                                  cur_warp;
  logic                                            warp_done;
  logic [WID-1:0]                                  done_warp_id;
  logic                                            stall_err;

  // Issue stage and cores drive the inputs; the scheduler is the slave side.
  modport master (
    output warp_req_valid, warp_active_mask, warp_opcode, warp_is_fp,
           warp_op1, warp_op2, core_ready,
    input  warp_req_ready, thread_valid, thread_opcode, thread_is_fp,
           thread_op1, thread_op2, busy, cur_warp, warp_done, done_warp_id, stall_err
  );

  modport slave (
    input  warp_req_valid, warp_active_mask, warp_opcode, warp_is_fp,
           warp_op1, warp_op2, core_ready,
    output warp_req_ready, thread_valid, thread_opcode, thread_is_fp,
           thread_op1, thread_op2, busy, cur_warp, warp_done, done_warp_id, stall_err
  );
endinterface

// File: rtl/warp_dispatch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 with wrap; last is held by the parent.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    for (int i = int'(N); i >= 1; i--) begin
      cand = IW'((32'(last) + 32'(i)) % 32'(N));
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end
endmodule

// File: rtl/warp_dispatch_scheduler.sv
// Round-robin warp selection and per-thread operand dispatch with pending-mask retirement.
module warp_dispatch_scheduler #(
  parameter int unsigned W           = 32,
  parameter int unsigned NUM_THREADS = 32,
  parameter int unsigned NUM_WARPS   = 4,
  parameter int unsigned STALL_LIMIT = 255
) (
  input logic                      clk,
  input logic                      rst,
  warp_dispatch_scheduler_if.slave bus
);
  import noc_sched_pkg::*;

  localparam int unsigned WID   = $clog2(NUM_WARPS);
  localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(STALL_LIMIT);

  sched_state_t                  state_q;
  logic [NUM_THREADS-1:0]        pending_q, pending_d;
  logic [OPCODE_W-1:0]           opcode_q;
  logic                          is_fp_q;
  logic [NUM_THREADS-1:0][W-1:0] op1_q, op2_q;
  logic [WID-1:0]                cur_warp_q, last_grant_q, done_id_q;
  logic                          warp_done_q, stall_err_q;
  logic [CNT_W-1:0]              stall_cnt_q, stall_cnt_d;
  logic [NUM_WARPS-1:0]          grant_c;
  logic [WID-1:0]                grant_idx_c;
  logic                          accept_c, dispatch_c;

  rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .req   (bus.warp_req_valid),
    .last  (last_grant_q),
    .grant (grant_c),
    .idx   (grant_idx_c)
  );

  assign accept_c = (state_q == IDLE) && (|bus.warp_req_valid);

  // Progress tracking: a cycle with any thread handshake resets the stall count.
  always_comb begin
    pending_d   = pending_q & ~bus.core_ready;
    dispatch_c  = |(pending_q & bus.core_ready);
    stall_cnt_d = stall_cnt_q;
    if (dispatch_c)
      stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      opcode_q     <= '0;
      is_fp_q      <= 1'b0;
      op1_q        <= '0;
      op2_q        <= '0;
      cur_warp_q   <= '0;
      last_grant_q <= WID'(NUM_WARPS - 1);
      done_id_q    <= '0;
      warp_done_q  <= 1'b0;
      stall_err_q  <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      warp_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            state_q      <= DISPATCH;
            pending_q    <= bus.warp_active_mask[grant_idx_c];
            opcode_q     <= bus.warp_opcode[grant_idx_c];
            is_fp_q      <= bus.warp_is_fp[grant_idx_c];
            op1_q        <= bus.warp_op1[grant_idx_c];
            op2_q        <= bus.warp_op2[grant_idx_c];
            cur_warp_q   <= grant_idx_c;
            last_grant_q <= grant_idx_c;
            stall_cnt_q  <= '0;
          end
        end
        DISPATCH: begin
          pending_q   <= pending_d;
          stall_cnt_q <= stall_cnt_d;
          if (stall_cnt_d == STALL_MAX)
            stall_err_q <= 1'b1;
          if (pending_d == '0) begin
            state_q     <= IDLE;
            warp_done_q <= 1'b1;
            done_id_q   <= cur_warp_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grant is presented only while idle and out of reset.
  assign bus.warp_req_ready = (rst && state_q == IDLE) ? grant_c : '0;
  assign bus.thread_valid   = pending_q;
  assign bus.thread_opcode  = {NUM_THREADS{opcode_q}};
  assign bus.thread_is_fp   = {NUM_THREADS{is_fp_q}};
  assign bus.thread_op1     = op1_q;
  assign bus.thread_op2     = op2_q;
  assign bus.busy           = (state_q == DISPATCH);
  assign bus.cur_warp       = cur_warp_q;
  assign bus.warp_done      = warp_done_q;
  assign bus.done_warp_id   = done_id_q;
  assign bus.stall_err      = stall_err_q;
endmodule

// File: tb/tb_warp_dispatch_scheduler.sv
// Directed bench for warp_dispatch_scheduler with hand-computed expectations.
module tb_warp_dispatch_scheduler;
  localparam int unsigned W  = 32;
  localparam int unsigned NT = 32;
  localparam int unsigned NW = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  warp_dispatch_scheduler_if #(.W(W), .NUM_THREADS(NT), .NUM_WARPS(NW)) bus ();

  warp_dispatch_scheduler #(
    .W(W), .NUM_THREADS(NT), .NUM_WARPS(NW), .STALL_LIMIT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int exp_order2[4] = '{2, 3, 0, 2};

  initial begin
    // Reset with random inputs applied
    rst = 1'b0;
    bus.warp_req_valid = 4'($urandom);
    bus.core_ready     = $urandom;
    bus.warp_is_fp     = 4'($urandom);
    for (int w = 0; w < int'(NW); w++) begin
      bus.warp_active_mask[w] = $urandom;
      bus.warp_opcode[w]      = 6'($urandom);
      for (int t = 0; t < int'(NT); t++) begin
        bus.warp_op1[w][t] = $urandom;
        bus.warp_op2[w][t] = $urandom;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.warp_req_ready), 64'h0);
    chk("rst_tvalid", 64'(bus.thread_valid), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.warp_done), 64'h0);
    chk("rst_stall", 64'(bus.stall_err), 64'h0);
    chk("rst_op1", 64'(bus.thread_op1[7]), 64'h0);
    chk("rst_opcode", 64'(bus.thread_opcode[0]), 64'h0);

    // Deterministic warp contents
    bus.warp_req_valid = '0;
    bus.core_ready     = '0;
    bus.warp_is_fp     = 4'b1010;
    for (int w = 0; w < int'(NW); w++) begin
      bus.warp_active_mask[w] = 32'hFFFF_FFFF;
      bus.warp_opcode[w]      = 6'(w + 5);
      for (int t = 0; t < int'(NT); t++) begin
        bus.warp_op1[w][t] = 32'hA000_0000 | 32'(w << 8) | 32'(t);
        bus.warp_op2[w][t] = 32'hB000_0000 | 32'(w << 8) | 32'(t);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle_ready", 64'(bus.warp_req_ready), 64'h0);
    chk("idle_busy", 64'(bus.busy), 64'h0);

    // Full warp 0, all cores ready
    bus.core_ready = 32'hFFFF_FFFF;
    bus.warp_req_valid = 4'b0001;
    #1;
    chk("full_ready", 64'(bus.warp_req_ready), 64'h1);
    tick();
    bus.warp_req_valid = '0;
    #1;
    chk("full_tvalid", 64'(bus.thread_valid), 64'hFFFF_FFFF);
    chk("full_busy", 64'(bus.busy), 64'h1);
    chk("full_ready_disp", 64'(bus.warp_req_ready), 64'h0);
    chk("full_cur", 64'(bus.cur_warp), 64'h0);
    chk("full_op1", 64'(bus.thread_op1[5]), 64'hA000_0005);
    chk("full_op2", 64'(bus.thread_op2[31]), 64'hB000_001F);
    chk("full_opcode", 64'(bus.thread_opcode[31]), 64'h5);
    chk("full_fp", 64'(bus.thread_is_fp), 64'h0);
    tick();
    chk("full_done", 64'(bus.warp_done), 64'h1);
    chk("full_done_id", 64'(bus.done_warp_id), 64'h0);
    chk("full_idle", 64'(bus.busy), 64'h0);
    chk("full_tv_idle", 64'(bus.thread_valid), 64'h0);
    tick();
    chk("full_done_pulse", 64'(bus.warp_done), 64'h0);

    // Partial acceptance on warp 1
    bus.warp_active_mask[1] = 32'h0000_000F;
    bus.core_ready = '0;
    bus.warp_req_valid = 4'b0010;
    #1;
    chk("part_ready", 64'(bus.warp_req_ready), 64'h2);
    tick();
    bus.warp_req_valid = '0;
    bus.core_ready = 32'h3;
    #1;
    chk("part_tv1", 64'(bus.thread_valid), 64'hF);
    chk("part_fp", 64'(bus.thread_is_fp), 64'hFFFF_FFFF);
    chk("part_opcode", 64'(bus.thread_opcode[0]), 64'h6);
    tick();
    bus.core_ready = 32'hC;
    #1;
    chk("part_tv2", 64'(bus.thread_valid), 64'hC);
    chk("part_op1_held", 64'(bus.thread_op1[2]), 64'hA000_0102);
    chk("part_nodone", 64'(bus.warp_done), 64'h0);
    tick();
    chk("part_done", 64'(bus.warp_done), 64'h1);
    chk("part_done_id", 64'(bus.done_warp_id), 64'h1);
    chk("part_tv3", 64'(bus.thread_valid), 64'h0);
    chk("part_op2_idle", 64'(bus.thread_op2[3]), 64'hB000_0103);

    // Empty mask on warp 2
    bus.core_ready = '0;
    bus.warp_active_mask[2] = '0;
    bus.warp_req_valid = 4'b0100;
    #1;
    chk("empty_ready", 64'(bus.warp_req_ready), 64'h4);
    tick();
    bus.warp_req_valid = '0;
    #1;
    chk("empty_busy", 64'(bus.busy), 64'h1);
    chk("empty_tv", 64'(bus.thread_valid), 64'h0);
    chk("empty_cur", 64'(bus.cur_warp), 64'h2);
    tick();
    chk("empty_done", 64'(bus.warp_done), 64'h1);
    chk("empty_done_id", 64'(bus.done_warp_id), 64'h2);
    chk("empty_idle", 64'(bus.busy), 64'h0);
    chk("empty_stall", 64'(bus.stall_err), 64'h0);

    // Stall on warp 3 with limit 4
    bus.warp_active_mask[3] = 32'h1;
    bus.warp_req_valid = 4'b1000;
    #1;
    chk("stall_ready", 64'(bus.warp_req_ready), 64'h8);
    tick();
    bus.warp_req_valid = '0;
    #1;
    chk("stall_err0", 64'(bus.stall_err), 64'h0);
    repeat (3) tick();
    chk("stall_err3", 64'(bus.stall_err), 64'h0);
    tick();
    chk("stall_err4", 64'(bus.stall_err), 64'h1);
    chk("stall_busy", 64'(bus.busy), 64'h1);
    chk("stall_tv", 64'(bus.thread_valid), 64'h1);
    bus.core_ready = 32'h1;
    tick();
    chk("stall_done", 64'(bus.warp_done), 64'h1);
    chk("stall_done_id", 64'(bus.done_warp_id), 64'h3);
    chk("stall_sticky", 64'(bus.stall_err), 64'h1);
    bus.core_ready = '0;

    // Reset in the middle of dispatching warp 0
    bus.warp_req_valid = 4'b0001;
    #1;
    chk("mrst_ready", 64'(bus.warp_req_ready), 64'h1);
    tick();
    bus.warp_req_valid = '0;
    #1;
    chk("mrst_busy", 64'(bus.busy), 64'h1);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("mrst_busy0", 64'(bus.busy), 64'h0);
    chk("mrst_tv0", 64'(bus.thread_valid), 64'h0);
    chk("mrst_stall0", 64'(bus.stall_err), 64'h0);
    chk("mrst_op1", 64'(bus.thread_op1[0]), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("mrst_nodone", 64'(bus.warp_done), 64'h0);
    chk("mrst_idle", 64'(bus.busy), 64'h0);

    // Round-robin with all warps requesting
    for (int w = 0; w < int'(NW); w++) bus.warp_active_mask[w] = 32'hFFFF_FFFF;
    bus.core_ready = 32'hFFFF_FFFF;
    bus.warp_req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("rr_ready", 64'(bus.warp_req_ready), 64'(1 << exp_order[k]));
      tick();
      chk("rr_cur", 64'(bus.cur_warp), 64'(exp_order[k]));
      tick();
      chk("rr_done_id", 64'(bus.done_warp_id), 64'(exp_order[k]));
    end
    bus.warp_req_valid = 4'b1101;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr2_ready", 64'(bus.warp_req_ready), 64'(1 << exp_order2[k]));
      tick();
      chk("rr2_cur", 64'(bus.cur_warp), 64'(exp_order2[k]));
      tick();
      chk("rr2_done", 64'(bus.warp_done), 64'h1);
    end
    bus.warp_req_valid = '0;
    tick();
    chk("end_idle", 64'(bus.busy), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
